// File: rtl/rate_sequencer_if.sv
// Run controls from the consumer and the strobe/status bundle returned by the rate sequencer.
// phase is sized for M2 base-band samples per audio sample.
interface rate_sequencer_if #(
  parameter int M2 = 30
);
  logic                  enable;
  logic                  resync;
  logic                  ce_b;
  logic                  ce_a;
  logic [$clog2(M2)-1:0] phase;
  logic                  valid;
  logic                  busy;

  modport master (
    output enable, resync,
    input  ce_b, ce_a, phase, valid, busy
  );

  modport slave (
    input  enable, resync,
    output ce_b, ce_a, phase, valid, busy
  );
endinterface

// File: rtl/rate_sequencer.sv
// Divides clk_s into base-band (every M1 cycles) and audio (every M1*M2 cycles) enable strobes.
// Strobes are decoded combinationally from the counters; valid follows WARMUP audio strobes.
module rate_sequencer #(
  parameter int M1     = 250,
  parameter int M2     = 30,
  parameter int WARMUP = 4
) (
  input  logic             clk_s,
  input  logic             reset_n,
  rate_sequencer_if.slave  sif
);
  localparam int W1 = $clog2(M1);
  localparam int W2 = $clog2(M2);
  localparam int WW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_t;

  state_t          state, state_nx;
  logic [W1-1:0]   cnt1, cnt1_nx;
  logic [W2-1:0]   cnt2, cnt2_nx;
  logic [WW-1:0]   wcnt, wcnt_nx;

  logic busy_w;
  logic at_end1;
  logic at_end2;
  logic ce_b_w;
  logic ce_a_w;

  assign busy_w  = (state != ST_IDLE);
  assign at_end1 = (cnt1 == W1'(M1 - 1));
  assign at_end2 = (cnt2 == W2'(M2 - 1));
  // enable/resync gate the strobe in the same cycle so a stop or restart never leaks a pulse
  assign ce_b_w  = busy_w && sif.enable && !sif.resync && at_end1;
  assign ce_a_w  = ce_b_w && at_end2;

  assign sif.ce_b  = ce_b_w;
  assign sif.ce_a  = ce_a_w;
  assign sif.phase = cnt2;
  assign sif.valid = (state == ST_RUN);
  assign sif.busy  = busy_w;

  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt1  <= '0;
      cnt2  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt1  <= cnt1_nx;
      cnt2  <= cnt2_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt1_nx  = cnt1;
    cnt2_nx  = cnt2;
    wcnt_nx  = wcnt;
    case (state)
      ST_IDLE: begin
        cnt1_nx = '0;
        cnt2_nx = '0;
        wcnt_nx = '0;
        if (sif.enable) state_nx = ST_WARMUP;
      end
      ST_WARMUP, ST_RUN: begin
        if (!sif.enable) begin
          state_nx = ST_IDLE;
          cnt1_nx  = '0;
          cnt2_nx  = '0;
          wcnt_nx  = '0;
        end else if (sif.resync) begin
          state_nx = ST_WARMUP;
          cnt1_nx  = '0;
          cnt2_nx  = '0;
          wcnt_nx  = '0;
        end else begin
          cnt1_nx = at_end1 ? '0 : cnt1 + W1'(1);
          if (at_end1) cnt2_nx = at_end2 ? '0 : cnt2 + W2'(1);
          // wcnt freezes once RUN is reached; only warm-up audio strobes are counted
          if (state == ST_WARMUP && ce_a_w) begin
            wcnt_nx = wcnt + WW'(1);
            if (wcnt == WW'(WARMUP - 1)) state_nx = ST_RUN;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt1_nx  = '0;
        cnt2_nx  = '0;
        wcnt_nx  = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_rate_sequencer.sv
// Bench for rate_sequencer: small-parameter instance against a time-since-start model,
// plus a default-parameter instance checked for strobe rate and spacing.
module tb_rate_sequencer;
  localparam int M1 = 4;
  localparam int M2 = 3;
  localparam int WU = 2;

  logic clk_s   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_s = ~clk_s;

  rate_sequencer_if #(.M2(M2)) sif ();
  rate_sequencer_if            dsif ();

  rate_sequencer #(.M1(M1), .M2(M2), .WARMUP(WU)) dut (
    .clk_s   (clk_s),
    .reset_n (reset_n),
    .sif     (sif)
  );

  rate_sequencer u_def (
    .clk_s   (clk_s),
    .reset_n (reset_n),
    .sif     (dsif)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: running flag plus cycles elapsed since the last start or restart.
  bit m_act = 1'b0;
  int m_t   = 0;

  always @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (!m_act) begin
      if (sif.enable) begin
        m_act = 1'b1;
        m_t   = 0;
      end
    end else if (!sif.enable) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (sif.resync) begin
      m_t = 0;
    end else begin
      m_t++;
    end
  end

  always @(negedge clk_s) begin : cmp
    bit e_ceb, e_cea, e_val;
    int e_ph;
    e_ceb = m_act && sif.enable && !sif.resync && ((m_t % M1) == M1 - 1);
    e_cea = e_ceb && (((m_t / M1) % M2) == M2 - 1);
    e_val = m_act && (m_t >= WU * M1 * M2);
    e_ph  = m_act ? (m_t / M1) % M2 : 0;
    chk("ce_b", sif.ce_b, e_ceb);
    chk("ce_a", sif.ce_a, e_cea);
    chk("valid", sif.valid, e_val);
    chk("busy", sif.busy, m_act);
    chk("phase", sif.phase, e_ph);
  end

  int ceb_q[$];
  int cea_q[$];
  int first_valid;
  int first_ceb;
  int d_nb, d_na, d_last, d_first;

  task automatic cyc();
    @(posedge clk_s);
    #1;
  endtask

  initial begin
    sif.enable  = 1'b0;
    sif.resync  = 1'b0;
    dsif.enable = 1'b0;
    dsif.resync = 1'b0;

    // reset state
    @(negedge clk_s);
    chk("reset_busy", sif.busy, 0);
    chk("reset_valid", sif.valid, 0);
    chk("reset_phase", sif.phase, 0);
    chk("reset_ce_b", sif.ce_b, 0);
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    @(negedge clk_s);
    chk("idle_without_enable", sif.busy, 0);

    // start-up timeline
    cyc();
    sif.enable = 1'b1;
    @(posedge clk_s);
    first_valid = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_s);
      if (sif.ce_b) ceb_q.push_back(c);
      if (sif.ce_a) begin
        cea_q.push_back(c);
        chk("startup_phase_at_ce_a", sif.phase, 2);
      end
      if (sif.valid && first_valid == 0) first_valid = c;
    end
    chk("startup_ce_b_count", ceb_q.size(), 7);
    for (int k = 0; k < ceb_q.size() && k < 7; k++) chk("startup_ce_b_cycle", ceb_q[k], 4 * (k + 1));
    chk("startup_ce_a_count", cea_q.size(), 2);
    if (cea_q.size() == 2) begin
      chk("startup_ce_a_first", cea_q[0], 12);
      chk("startup_ce_a_second", cea_q[1], 24);
    end
    chk("startup_valid_cycle", first_valid, 25);

    // resync in RUN
    cyc();
    sif.resync = 1'b1;
    cyc();
    sif.resync = 1'b0;
    first_ceb   = 0;
    first_valid = 0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk_s);
      if (c == 1) begin
        chk("resync_valid_drop", sif.valid, 0);
        chk("resync_busy", sif.busy, 1);
        chk("resync_phase", sif.phase, 0);
      end
      if (sif.ce_b && first_ceb == 0) first_ceb = c;
      if (sif.valid && first_valid == 0) first_valid = c;
    end
    chk("resync_first_ce_b", first_ceb, 4);
    chk("resync_valid_return", first_valid, 25);

    // enable=0 and resync=1 together, in a cycle that would otherwise strobe
    for (int i = 0; i < M1; i++) begin
      cyc();
      if ((m_t % M1) == M1 - 1) break;
    end
    sif.enable = 1'b0;
    sif.resync = 1'b1;
    @(negedge clk_s);
    chk("prio_no_ce_b", sif.ce_b, 0);
    chk("prio_busy_same_cycle", sif.busy, 1);
    cyc();
    sif.resync = 1'b0;
    @(negedge clk_s);
    chk("prio_busy_next", sif.busy, 0);

    // asynchronous reset mid-RUN
    cyc();
    sif.enable = 1'b1;
    repeat (30) @(posedge clk_s);
    #2;
    chk("pre_reset_valid", sif.valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_busy", sif.busy, 0);
    chk("async_valid", sif.valid, 0);
    chk("async_phase", sif.phase, 0);
    chk("async_ce_b", sif.ce_b, 0);
    chk("async_ce_a", sif.ce_a, 0);
    cyc();
    reset_n = 1'b1;
    @(negedge clk_s);
    chk("post_reset_idle", sif.busy, 0);

    // randomized run
    repeat (3000) begin
      cyc();
      sif.enable = ($urandom_range(0, 99) != 0);
      sif.resync = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset_n = 1'b0;
        #4;
        reset_n = 1'b1;
      end
    end

    // default parameters: 100 us at 240 MHz
    cyc();
    sif.enable  = 1'b0;
    sif.resync  = 1'b0;
    dsif.enable = 1'b1;
    @(posedge clk_s);
    d_nb = 0; d_na = 0; d_last = 0; d_first = 0;
    for (int c = 1; c <= 24000; c++) begin
      @(negedge clk_s);
      if (dsif.ce_b) begin
        d_nb++;
        if (d_last > 0) chk("def_ce_b_spacing", c - d_last, 250);
        else d_first = c;
        d_last = c;
      end
      if (dsif.ce_a) begin
        d_na++;
        chk("def_ce_a_with_ce_b", dsif.ce_b, 1);
        chk("def_phase_at_ce_a", dsif.phase, 29);
      end
    end
    chk("def_first_ce_b", d_first, 250);
    chk("def_ce_b_count_96pm1", (d_nb >= 95 && d_nb <= 97), 1);
    chk("def_ce_a_count_3pm1", (d_na >= 2 && d_na <= 4), 1);
    chk("def_still_warming", dsif.valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rate_sequencer.md
RATE_SEQUENCER -- requirements
Module: rate_sequencer

Interface
REQ-001 Parameter M1, default 250: number of clk_s cycles per base-band sample (carrier to broad-band ratio); legal range 2 or more.
REQ-002 Parameter M2, default 30: number of base-band samples per audio sample; legal range 2 or more.
REQ-003 Parameter WARMUP, default 4: number of ce_a strobes issued before valid asserts (filter settling); legal range 1 or more.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk_s  input  1  240 MHz sampling clock; the only clock in the block.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  run request; level-sensitive and sampled on every rising clk_s edge.
REQ-008 resync  input  1  single-cycle request to restart the strobe phase and repeat warm-up.
REQ-009 ce_b  output  1  base-band clock-enable strobe, one clk_s cycle wide.
REQ-010 ce_a  output  1  audio clock-enable strobe, one clk_s cycle wide.
REQ-011 phase  output  $clog2(M2)  current base-band index within the audio period (cnt2).
REQ-012 valid  output  1  high when downstream filter outputs are settled.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement three states: IDLE, WARMUP and RUN, held in registers.
REQ-015 The block SHALL hold three counters: cnt1 (width $clog2(M1), range 0..M1-1), cnt2 (width $clog2(M2), range 0..M2-1) and wcnt (width $clog2(WARMUP+1)).
REQ-016 In IDLE, all counters SHALL be zero and ce_b, ce_a, valid and busy SHALL be 0.
REQ-017 On an edge where the block is in IDLE and enable=1, the block SHALL enter WARMUP with cnt1=0.
REQ-018 In WARMUP and RUN, cnt1 SHALL increment every cycle and wrap from M1-1 to 0.
REQ-019 cnt2 SHALL increment only when cnt1 wraps, and SHALL wrap from M2-1 to 0.
REQ-020 ce_b SHALL equal busy AND enable AND NOT resync AND (cnt1==M1-1), decoded from registers with no added latency.
REQ-021 ce_a SHALL equal ce_b AND (cnt2==M2-1); ce_a therefore never asserts without ce_b.
REQ-022 phase SHALL equal cnt2 at all times.
REQ-023 In WARMUP, wcnt SHALL increment on each ce_a.
REQ-024 When ce_a occurs with wcnt==WARMUP-1, the block SHALL enter RUN on the next edge.
REQ-025 valid SHALL be 1 exactly when the block is in RUN.
REQ-026 In RUN, wcnt SHALL hold its value.
REQ-027 enable=0 sampled in WARMUP or RUN SHALL send the block to IDLE on the next edge and clear all counters.
REQ-028 Strobes SHALL be suppressed in the cycle where enable=0.
REQ-029 resync=1 in WARMUP or RUN SHALL, on the next edge, clear cnt1, cnt2 and wcnt and enter WARMUP; valid drops from that edge.
REQ-030 resync SHALL be ignored in IDLE.
REQ-031 If enable=0 and resync=1 occur in the same cycle, enable SHALL take priority and the block SHALL go to IDLE.
REQ-032 Steady state SHALL produce exactly one ce_b per M1 cycles and one ce_a per M1*M2 cycles, with no drift.

Reset
REQ-033 reset_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, clear all counters and drive ce_b, ce_a, valid, busy and phase to 0.
REQ-034 reset_n=0 asserted mid-WARMUP or mid-RUN SHALL abort the operation with no further strobes.
REQ-035 After reset_n rises, the block SHALL remain in IDLE until enable=1 is sampled.

Verification (M1=4, M2=3, WARMUP=2 unless stated; WARMUP cycles numbered from 1)
REQ-036 Start-up: enable rises and is held -> ce_b in cycles 4, 8, 12, 16, 20, 24; ce_a in cycles 12 and 24; phase is 2 at each ce_a; valid=1 from cycle 25.
REQ-037 Resync: resync pulsed in RUN -> valid=0 on the next edge, cnt1 restarts at 0, next ce_b occurs 4 cycles after WARMUP re-entry, valid returns after 24 further cycles.
REQ-038 Priority: enable=0 and resync=1 in the same cycle -> IDLE, busy=0 next edge, no strobe in that cycle.
REQ-039 Asynchronous reset: reset_n pulsed low between clk_s edges during RUN -> all outputs 0 before the next edge; no strobe until enable is resampled.
REQ-040 Defaults: M1=250, M2=30, 240 MHz, 100 us run -> 96 ce_b and 3 ce_a (±1); every ce_a coincident with ce_b and phase==29; ce_b spacing always exactly 250 cycles.
